// File: rtl/bus_cycle_controller.sv
// 8088 minimum-mode bus cycle sequencer: address latch, region decode, wait-state insertion.
// Optional BUS_TIMEOUT_EN adds a per-cycle watchdog that forces the cycle back to IDLE.
`timescale 1ns/1ps
module bus_cycle_controller #(
  parameter logic [79:0] REGION_BASE    = {20'h00090, 20'h00080, 20'hF0000, 20'h00000},
  parameter logic [79:0] REGION_MASK    = {20'hFFFF0, 20'hFFFF0, 20'hF0000, 20'hF0000},
  parameter logic [3:0]  REGION_IO      = 4'b1100,
  parameter logic [15:0] REGION_WS      = {4'd3, 4'd1, 4'd2, 4'd0},
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        ALE,
  input  logic        IOM,
  input  logic        RD,
  input  logic        WR,
  input  logic [7:0]  AD,
  input  logic [11:0] A,
  output logic [19:0] Address,
  output logic [3:0]  CS,
  output logic        READY,
  output logic        MISS,
  output logic        BUSY,
  output logic        TIMEOUT,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LATCH = 3'd1,
    S_ARMED = 3'd2,
    S_WAIT  = 3'd3,
    S_XFER  = 3'd4
  } state_t;

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be within 2..255");
  end

  state_t     state;
  logic       iom_q;
  logic [3:0] wcnt;
  logic       strobe;
  logic [3:0] hit_cs;
  logic [3:0] hit_ws;
  logic       hit_any;

  // RD and WR low together count as one strobe.
  assign strobe    = !RD || !WR;
  assign dbg_state = state;

  // Walk regions high to low so the lowest-index hit is the one that sticks.
  always_comb begin
    hit_cs  = 4'b0000;
    hit_ws  = 4'd0;
    hit_any = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (((Address & REGION_MASK[i*20 +: 20]) ==
           (REGION_BASE[i*20 +: 20] & REGION_MASK[i*20 +: 20])) &&
          (REGION_IO[i] == !iom_q)) begin
        hit_cs  = 4'b0001 << i;
        hit_ws  = REGION_WS[i*4 +: 4];
        hit_any = 1'b1;
      end
    end
  end

`ifdef BUS_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       active;
  logic       timeout_hit;

  assign active      = (state == S_ARMED) || (state == S_WAIT) || (state == S_XFER);
  assign timeout_hit = active && (tcnt == 8'(TIMEOUT_CYCLES));
`endif

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= S_IDLE;
      Address <= 20'h00000;
      iom_q   <= 1'b0;
      CS      <= 4'b0000;
      READY   <= 1'b1;
      MISS    <= 1'b0;
      BUSY    <= 1'b0;
      wcnt    <= 4'd0;
`ifdef BUS_TIMEOUT_EN
      tcnt    <= 8'd0;
      TIMEOUT <= 1'b0;
`endif
    end else begin
      MISS <= 1'b0;
`ifdef BUS_TIMEOUT_EN
      TIMEOUT <= 1'b0;
`endif
      if (ALE) begin
        // ALE wins in every state, aborting whatever cycle was in flight.
        Address <= {A, AD};
        iom_q   <= IOM;
        CS      <= 4'b0000;
        READY   <= 1'b1;
        BUSY    <= 1'b1;
        wcnt    <= 4'd0;
        state   <= S_LATCH;
`ifdef BUS_TIMEOUT_EN
        tcnt    <= 8'd0;
`endif
      end else begin
        case (state)
          S_IDLE: begin
            BUSY <= 1'b0;
          end
          S_LATCH: begin
            if (hit_any) begin
              CS    <= hit_cs;
              state <= S_ARMED;
            end else begin
              MISS  <= 1'b1;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end
          end
          S_ARMED: begin
            if (strobe) begin
              if (hit_ws == 4'd0) begin
                state <= S_XFER;
              end else begin
                wcnt  <= hit_ws;
                READY <= 1'b0;
                state <= S_WAIT;
              end
            end
          end
          S_WAIT: begin
            // The counted wait always completes, even if the strobe has gone away.
            if (wcnt == 4'd1) begin
              wcnt  <= 4'd0;
              READY <= 1'b1;
              state <= S_XFER;
            end else begin
              wcnt <= wcnt - 4'd1;
            end
          end
          S_XFER: begin
            if (!strobe) begin
              CS    <= 4'b0000;
              BUSY  <= 1'b0;
              state <= S_IDLE;
            end
          end
          default: begin
            CS    <= 4'b0000;
            READY <= 1'b1;
            BUSY  <= 1'b0;
            state <= S_IDLE;
          end
        endcase
`ifdef BUS_TIMEOUT_EN
        if (active) begin
          tcnt <= tcnt + 8'd1;
        end
        if (timeout_hit) begin
          CS      <= 4'b0000;
          READY   <= 1'b1;
          BUSY    <= 1'b0;
          wcnt    <= 4'd0;
          TIMEOUT <= 1'b1;
          state   <= S_IDLE;
        end
`endif
      end
    end
  end

`ifndef BUS_TIMEOUT_EN
  assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_cycle_controller.sv
// Bench for bus_cycle_controller: directed vector table, abort/reset/long-hold sequences,
// then randomized bus cycles checked against a transaction-level model.
`timescale 1ns/1ps
module tb_bus_cycle_controller;

`ifdef BUS_TIMEOUT_EN
  localparam int TO_CYC = 8;
`else
  localparam int TO_CYC = 64;
`endif
  localparam logic [79:0] BASE = {20'h00090, 20'h00080, 20'hF0000, 20'h00000};
  localparam logic [79:0] MASK = {20'hFFFF0, 20'hFFFF0, 20'hF0000, 20'hF0000};
  localparam logic [3:0]  IOSP = 4'b1100;
  localparam logic [15:0] WSV  = {4'd3, 4'd1, 4'd2, 4'd0};

  logic        CLK = 1'b0;
  logic        RESET, ALE, IOM, RD, WR;
  logic [7:0]  AD;
  logic [11:0] A;
  logic [19:0] Address;
  logic [3:0]  CS;
  logic        READY, MISS, BUSY, TIMEOUT;
  logic [2:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  bus_cycle_controller #(
    .REGION_BASE(BASE), .REGION_MASK(MASK), .REGION_IO(IOSP),
    .REGION_WS(WSV), .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .CLK(CLK), .RESET(RESET), .ALE(ALE), .IOM(IOM), .RD(RD), .WR(WR),
    .AD(AD), .A(A), .Address(Address), .CS(CS), .READY(READY),
    .MISS(MISS), .BUSY(BUSY), .TIMEOUT(TIMEOUT), .dbg_state(dbg_state)
  );

  // Clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [19:0] addr;
    logic        iom;
    logic        use_wr;
    int          delay;
    int          len;
    logic [3:0]  exp_cs;
    logic        exp_miss;
    int          exp_low;
    int          exp_hold;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Reference: first region (lowest index) whose masked base and address space match.
  function automatic void model(input logic [19:0] addr, input logic iom,
                                output logic [3:0] cs, output int ws);
    cs = 4'b0000;
    ws = 0;
    for (int i = 0; i < 4; i++) begin
      if (cs == 4'b0000 && ((addr & MASK[i*20 +: 20]) == (BASE[i*20 +: 20] & MASK[i*20 +: 20]))
          && (IOSP[i] != iom)) begin
        cs = 4'b0001 << i;
        ws = int'(WSV[i*4 +: 4]);
      end
    end
  endfunction

  // Driver: one full bus cycle, strobe low for len edges starting delay edges after decode.
  task automatic run_txn(input string tag, input logic [19:0] addr, input logic iom,
                         input logic use_wr, input int delay, input int len,
                         input logic [3:0] exp_cs, input logic exp_miss,
                         input int exp_low, input int exp_hold);
    int low, hold, bad;
    A = addr[19:8]; AD = addr[7:0]; IOM = iom; ALE = 1'b1;
    tick();
    chk({tag, " address"}, 32'(Address), 32'(addr));
    chk({tag, " busy"}, 32'(BUSY), 32'd1);
    ALE = 1'b0;
    tick();
    chk({tag, " cs"}, 32'(CS), 32'(exp_cs));
    chk({tag, " miss"}, 32'(MISS), 32'(exp_miss));
    if (exp_miss) begin
      tick();
      chk({tag, " miss_clear"}, 32'(MISS), 32'd0);
      chk({tag, " idle_busy"}, 32'(BUSY), 32'd0);
      chk({tag, " idle_ready"}, 32'(READY), 32'd1);
      return;
    end
    for (int d = 0; d < delay; d++) tick();
    if (use_wr) WR = 1'b0; else RD = 1'b0;
    low = 0; hold = 0; bad = 0;
    for (int j = 0; j < 40; j++) begin
      if (j == len) begin RD = 1'b1; WR = 1'b1; end
      tick();
      if (!READY) low++;
      if (CS == 4'b0000) break;
      hold++;
      if (CS !== exp_cs) bad++;
    end
    RD = 1'b1; WR = 1'b1;
    chk({tag, " ready_low"}, 32'(low), 32'(exp_low));
    chk({tag, " cs_hold"}, 32'(hold), 32'(exp_hold));
    chk({tag, " cs_stable"}, 32'(bad), 32'd0);
    chk({tag, " end_busy"}, 32'(BUSY), 32'd0);
    chk({tag, " end_ready"}, 32'(READY), 32'd1);
  endtask

  initial begin
    logic [3:0]  m_cs;
    int          m_ws, len, delay, hold, to_cnt, to_first;
    logic [19:0] addr;
    logic        iom;

    vecs[0] = '{20'h01234, 1'b1, 1'b0, 0, 4, 4'b0001, 1'b0, 0, 4};
    vecs[1] = '{20'hF8000, 1'b1, 1'b0, 0, 3, 4'b0010, 1'b0, 2, 3};
    vecs[2] = '{20'h00085, 1'b0, 1'b1, 0, 2, 4'b0100, 1'b0, 1, 2};
    vecs[3] = '{20'h00085, 1'b1, 1'b0, 1, 1, 4'b0001, 1'b0, 0, 1};
    vecs[4] = '{20'h00040, 1'b0, 1'b0, 0, 1, 4'b0000, 1'b1, 0, 0};
    vecs[5] = '{20'h00093, 1'b0, 1'b1, 2, 6, 4'b1000, 1'b0, 3, 6};
    vecs[6] = '{20'h0009F, 1'b0, 1'b0, 0, 1, 4'b1000, 1'b0, 3, 4};
    vecs[7] = '{20'hF0000, 1'b0, 1'b0, 0, 1, 4'b0000, 1'b1, 0, 0};
    vecs[8] = '{20'hFFFFF, 1'b1, 1'b0, 0, 2, 4'b0010, 1'b0, 2, 3};
    vecs[9] = '{20'h0008F, 1'b0, 1'b1, 1, 5, 4'b0100, 1'b0, 1, 5};

    RESET = 1'b0; ALE = 1'b0; IOM = 1'b1; RD = 1'b1; WR = 1'b1; AD = 8'h00; A = 12'h000;
    tick(); tick();
    chk("reset address", 32'(Address), 32'd0);
    chk("reset cs", 32'(CS), 32'd0);
    chk("reset ready", 32'(READY), 32'd1);
    chk("reset miss", 32'(MISS), 32'd0);
    chk("reset busy", 32'(BUSY), 32'd0);
    chk("reset timeout", 32'(TIMEOUT), 32'd0);
    RESET = 1'b1;
    tick();

    for (int v = 0; v < 10; v++) begin
      run_txn($sformatf("vec%0d", v), vecs[v].addr, vecs[v].iom, vecs[v].use_wr,
              vecs[v].delay, vecs[v].len, vecs[v].exp_cs, vecs[v].exp_miss,
              vecs[v].exp_low, vecs[v].exp_hold);
    end

    // ALE in the middle of a wait aborts the cycle and restarts decode.
    A = 12'h000; AD = 8'h93; IOM = 1'b0; ALE = 1'b1; tick();
    ALE = 1'b0; tick();
    chk("abort first cs", 32'(CS), 32'b1000);
    RD = 1'b0; tick();
    chk("abort in wait ready", 32'(READY), 32'd0);
    A = 12'h012; AD = 8'h34; IOM = 1'b1; ALE = 1'b1; tick();
    chk("abort cs", 32'(CS), 32'd0);
    chk("abort ready", 32'(READY), 32'd1);
    chk("abort address", 32'(Address), 32'h01234);
    chk("abort busy", 32'(BUSY), 32'd1);
    ALE = 1'b0; RD = 1'b1; tick();
    chk("abort new cs", 32'(CS), 32'b0001);
    RD = 1'b0; tick();
    RD = 1'b1; tick();
    chk("abort end cs", 32'(CS), 32'd0);
    chk("abort end busy", 32'(BUSY), 32'd0);

    // Reset during WAIT clears everything at the first reset edge.
    A = 12'h000; AD = 8'h93; IOM = 1'b0; ALE = 1'b1; tick();
    ALE = 1'b0; tick();
    RD = 1'b0; tick(); tick();
    RESET = 1'b0; tick();
    chk("midreset address", 32'(Address), 32'd0);
    chk("midreset cs", 32'(CS), 32'd0);
    chk("midreset ready", 32'(READY), 32'd1);
    chk("midreset busy", 32'(BUSY), 32'd0);
    chk("midreset miss", 32'(MISS), 32'd0);
    tick();
    RESET = 1'b1; RD = 1'b1; tick();
    chk("postreset busy", 32'(BUSY), 32'd0);
    chk("postreset cs", 32'(CS), 32'd0);

    // RD held low for 20 cycles on region 3.
    A = 12'h000; AD = 8'h90; IOM = 1'b0; ALE = 1'b1; tick();
    ALE = 1'b0; tick();
    chk("long cs", 32'(CS), 32'b1000);
    RD = 1'b0; hold = 0; to_cnt = 0; to_first = -1;
    for (int j = 0; j < 26; j++) begin
      if (j == 20) RD = 1'b1;
      tick();
      if (CS != 4'b0000) hold++;
      if (TIMEOUT) begin
        to_cnt++;
        if (to_first < 0) begin
          to_first = j;
          chk("timeout cs", 32'(CS), 32'd0);
          chk("timeout ready", 32'(READY), 32'd1);
        end
      end
    end
    RD = 1'b1;
`ifdef BUS_TIMEOUT_EN
    chk("long hold", 32'(hold), 32'd8);
    chk("timeout pulses", 32'(to_cnt), 32'd1);
    chk("timeout position", 32'(to_first), 32'd8);
`else
    chk("long hold", 32'(hold), 32'd20);
    chk("timeout pulses", 32'(to_cnt), 32'd0);
`endif
    chk("long end busy", 32'(BUSY), 32'd0);
    tick();

    // Randomized cycles against the transaction model.
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 4))
        0: addr = {4'h0, 16'($urandom)};
        1: addr = {4'hF, 16'($urandom)};
        2: addr = {16'h0008, 4'($urandom)};
        3: addr = {16'h0009, 4'($urandom)};
        default: addr = 20'($urandom);
      endcase
      iom   = 1'($urandom_range(0, 1));
      delay = $urandom_range(0, 1);
      len   = $urandom_range(1, 4);
      model(addr, iom, m_cs, m_ws);
      run_txn($sformatf("rnd%0d", t), addr, iom, 1'($urandom_range(0, 1)), delay, len,
              m_cs, (m_cs == 4'b0000), m_ws, (len > m_ws + 1) ? len : m_ws + 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
